// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_pkg
//  Description : Shared types, widths and helpers for the data-memory responder
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dm_state_t;

    function automatic int dm_idx_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder_if
//  Description : Request/ready/done bus between the memory stage and the responder
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_responder_if;
    import dm_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, done, rdata, err
    );

endinterface
`default_nettype wire

// File: rtl/dm_array.sv
`default_nettype none
// ============================================================================
//  Module      : dm_array
//  Description : Single-port word RAM; read data is registered and reads as zero
//                in any cycle that did not follow a read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
import dm_pkg::*;

module dm_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [IDX_W-1:0]  i_idx,
    input  wire logic [WORD_W-1:0] i_wdata,
    output logic      [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_q;

    // Contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_idx];
        end else begin
            r_q <= '0;
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder
//  Description : Multi-cycle data-memory slave with programmable latency and
//                misalignment / out-of-range error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
import dm_pkg::*;

module dm_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dm_responder_if.slave bus
);

    localparam int               c_IDX_W    = dm_idx_w(DEPTH);
    localparam logic [1:0]       c_S_IDLE   = IDLE;
    localparam logic [1:0]       c_S_BUSY   = BUSY;
    localparam logic [1:0]       c_S_RESP   = RESP;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    if ((DEPTH < 2) || (DEPTH > 65536) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dm_responder: DEPTH must be a power of two in 2..65536");
    end
    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("dm_responder: LATENCY must be in 1..15");
    end

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_err;

    logic              w_idle;
    logic              w_acc_we;
    logic [WORD_W-1:0] w_acc_addr;
    logic [WORD_W-1:0] w_acc_wdata;
    logic              w_bad;
    logic              w_enter_resp;
    logic              w_commit;
    logic [WORD_W-1:0] w_q;

    // With LATENCY=1 the access happens on the accepting edge, so the live
    // bus fields are used instead of the (not yet loaded) captured copy.
    assign w_idle      = (r_state == c_S_IDLE);
    assign w_acc_we    = w_idle ? bus.we    : r_we;
    assign w_acc_addr  = w_idle ? bus.addr  : r_addr;
    assign w_acc_wdata = w_idle ? bus.wdata : r_wdata;

    assign w_bad = (|w_acc_addr[1:0]) || (|(w_acc_addr >> (c_IDX_W + 2)));

    assign w_enter_resp = (w_idle && bus.req && (LATENCY == 1)) ||
                          ((r_state == c_S_BUSY) && (r_cnt == c_CNT_ONE));
    assign w_commit     = w_enter_resp && !reset;

    dm_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_commit && w_acc_we && !w_bad),
        .i_re    (w_commit && !w_acc_we && !w_bad),
        .i_idx   (w_acc_addr[c_IDX_W+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= c_CNT_LOAD;
                        if (LATENCY == 1) begin
                            r_state <= c_S_RESP;
                            r_err   <= w_bad;
                        end else begin
                            r_state <= c_S_BUSY;
                        end
                    end
                end
                c_S_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_S_RESP;
                        r_err   <= w_bad;
                    end
                end
                c_S_RESP: begin
                    r_state <= c_S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = w_idle;
    assign bus.done  = (r_state == c_S_RESP);
    assign bus.rdata = w_q;
    assign bus.err   = r_err;

endmodule
`default_nettype wire
